// File: rtl/serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// serial_add_ctrl
//
// Bit-serial adder controller. A single gate-level FullAdder cell is
// time-shared across a WIDTH-bit operand pair: operands and carry-in are
// latched on an accepted start, then one bit per clock is fed to the cell,
// LSB first, with the carry recirculated through a flop. The registered
// WIDTH-bit sum and carry-out are published together with a one-cycle done
// pulse. Latency is traded for area versus a WIDTH-cell ripple adder.
//
// Ports
//   clk          in   1      sole clock, rising edge
//   rst          in   1      synchronous, active-high reset
//   start        in   1      operation request (sampled only in IDLE)
//   a            in   WIDTH  operand A, captured on the accepting edge
//   b            in   WIDTH  operand B, captured on the accepting edge
//   cin          in   1      carry-in, captured on the accepting edge
//   busy         out  1      high while RUN or DONE
//   done         out  1      one-cycle pulse, sum/cout valid
//   sum          out  WIDTH  registered result, held until next completion
//   cout         out  1      registered carry-out, held until next completion
//   o_dbg_state  out  2      current FSM state (debug observation only)
//
// Request handshake: a request is accepted on any rising edge where
// start=1 and busy=0 (FSM in IDLE). While busy=1, start is ignored -- it is
// neither queued nor latched -- so a requester must wait for busy=0 and keep
// start high until the edge on which busy is observed low. A completed
// operation is signalled by done=1 for exactly one cycle; sum/cout stay
// valid after that until the next operation completes.
// -----------------------------------------------------------------------------

// Gate-level one-bit full adder: the single arithmetic cell of the datapath.
//   A, B, Cin  in   1  addend bits and carry-in
//   Sum, Cout  out  1  sum bit and carry-out
module FullAdder (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic Sum,
  output logic Cout
);

  logic w_axb;
  logic w_ab;
  logic w_cx;

  xor g_x0 (w_axb, A, B);
  xor g_x1 (Sum, w_axb, Cin);
  and g_a0 (w_ab, A, B);
  and g_a1 (w_cx, w_axb, Cin);
  or  g_o0 (Cout, w_ab, w_cx);

endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic [1:0]       o_dbg_state
);

  // Counter must be able to hold WIDTH, the value it reaches after the
  // final bit has been processed.
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  state_t           r_state;
  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic [WIDTH-1:0] r_sr;
  logic             r_c;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;

  // ---------------------------------------------------------------------------
  // Combinational signals
  // ---------------------------------------------------------------------------
  state_t           w_state_next;
  logic             w_load;     // accept a request this edge
  logic             w_step;     // process one bit this edge
  logic             w_last;     // this edge processes bit WIDTH-1
  logic             w_fa_sum;
  logic             w_fa_cout;
  logic [WIDTH-1:0] w_sr_next;

  // ---------------------------------------------------------------------------
  // The shared adder cell: always looks at the current LSBs and carry flop.
  // Its outputs are only consumed while stepping.
  // ---------------------------------------------------------------------------
  FullAdder u_fa (
    .A    (r_sa[0]),
    .B    (r_sb[0]),
    .Cin  (r_c),
    .Sum  (w_fa_sum),
    .Cout (w_fa_cout)
  );

  // New sum bit enters at the MSB so that after WIDTH steps the first bit
  // computed (bit 0) has walked down to position 0.
  generate
    if (WIDTH == 1) begin : g_sr_w1
      assign w_sr_next = w_fa_sum;
    end else begin : g_sr_wn
      assign w_sr_next = {w_fa_sum, r_sr[WIDTH-1:1]};
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // FSM: next-state and control decode
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_step       = 1'b0;
    w_last       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_load       = 1'b1;
          w_state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        w_step = 1'b1;
        if (r_cnt == LAST_BIT) begin
          w_last       = 1'b1;
          w_state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        // Mandatory single cycle back in IDLE before the next acceptance.
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sa   <= '0;
      r_sb   <= '0;
      r_sr   <= '0;
      r_c    <= 1'b0;
      r_cnt  <= '0;
      r_sum  <= '0;
      r_cout <= 1'b0;
    end else begin
      if (w_load) begin
        r_sa  <= a;
        r_sb  <= b;
        r_c   <= cin;
        r_cnt <= '0;
      end
      if (w_step) begin
        r_c   <= w_fa_cout;
        r_sr  <= w_sr_next;
        r_sa  <= r_sa >> 1;
        r_sb  <= r_sb >> 1;
        r_cnt <= r_cnt + CW'(1);
      end
      // Published result changes only here, so it stays stable while the
      // following operation is still running.
      if (w_last) begin
        r_sum  <= w_sr_next;
        r_cout <= w_fa_cout;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign busy        = (r_state == ST_RUN) || (r_state == ST_DONE);
  assign done        = (r_state == ST_DONE);
  assign sum         = r_sum;
  assign cout        = r_cout;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// tb_serial_add_ctrl
//
// Directed bench for serial_add_ctrl at WIDTH=8, WIDTH=1 and WIDTH=4, each
// instance on the shared clock and reset. Inputs are driven and outputs
// sampled on the falling edge; the DUT acts on the rising edge.
// -----------------------------------------------------------------------------
module tb_serial_add_ctrl;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // DUT signals
  // ---------------------------------------------------------------------------
  logic       start8, cin8, busy8, done8, cout8;
  logic [7:0] a8, b8, sum8;
  logic [1:0] st8;

  logic       start1, cin1, busy1, done1, cout1;
  logic [0:0] a1, b1, sum1;
  logic [1:0] st1;

  logic       start4, cin4, busy4, done4, cout4;
  logic [3:0] a4, b4, sum4;
  logic [1:0] st4;

  serial_add_ctrl #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .o_dbg_state(st8)
  );

  serial_add_ctrl #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .o_dbg_state(st1)
  );

  serial_add_ctrl #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .cin(cin4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .o_dbg_state(st4)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard counters and checker
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver: one WIDTH=8 operation with latency, busy length and result-hold
  // checks. prev_s/prev_c is the result that must stay visible until done.
  // ---------------------------------------------------------------------------
  task automatic op8(input string tag, input logic [7:0] a, input logic [7:0] b,
                     input logic ci, input logic [7:0] prev_s, input logic prev_c,
                     input logic [7:0] exp_s, input logic exp_c);
    int n;
    int busy_n;
    int hold_bad;
    @(negedge clk);
    start8 = 1'b1;
    a8     = a;
    b8     = b;
    cin8   = ci;
    @(negedge clk);               // accepting edge E0 has just passed
    start8   = 1'b0;
    n        = 0;
    busy_n   = 0;
    hold_bad = 0;
    while (!done8 && n < 40) begin
      if (busy8) busy_n++;
      if (sum8 !== prev_s || cout8 !== prev_c) hold_bad++;
      @(negedge clk);
      n++;
    end
    if (busy8) busy_n++;
    check({tag, "_lat"},  32'(n), 32'd8);
    check({tag, "_sum"},  32'(sum8), 32'(exp_s));
    check({tag, "_cout"}, 32'(cout8), 32'(exp_c));
    check({tag, "_hold"}, 32'(hold_bad), 32'd0);
    @(negedge clk);
    if (busy8) busy_n++;
    check({tag, "_busy_len"}, 32'(busy_n), 32'd9);
    check({tag, "_idle"}, {30'd0, busy8, done8}, 32'd0);
  endtask

  // Full-adder truth table indexed by {a,b,cin}, value {cout,sum}.
  logic [1:0] fa_tbl [8] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};

  logic [8:0] exp_q [$];

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    int         n;
    int         dones;
    int         busy_n;
    int         act;
    int         gap;
    int         seen;
    int         idx;
    logic [7:0] s_got;
    logic       c_got;
    logic [8:0] v;
    logic [8:0] e;

    // Reset, with start1 held high throughout.
    rst    = 1'b1;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
    start1 = 1'b1; a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_busy8", 32'(busy8), 32'd0);
    check("rst_done8", 32'(done8), 32'd0);
    check("rst_sum8",  32'(sum8),  32'd0);
    check("rst_cout8", 32'(cout8), 32'd0);
    check("rst_w1",    {28'd0, busy1, done1, sum1, cout1}, 32'd0);
    check("rst_w4",    {26'd0, busy4, done4, sum4}, 32'd0);
    rst = 1'b0;
    @(negedge clk);               // first edge after reset release accepts
    check("rst_start_busy1", 32'(busy1), 32'd1);
    start1 = 1'b0;
    @(negedge clk);
    check("rst_start_done1", 32'(done1), 32'd1);
    check("rst_start_res1",  {30'd0, cout1, sum1}, 32'b11);
    @(negedge clk);

    // Basic operation, full carry ripple, and result hold.
    op8("t5a3c",   8'h5A, 8'h3C, 1'b0, 8'h00, 1'b0, 8'h96, 1'b0);
    op8("tff00",   8'hFF, 8'h00, 1'b1, 8'h96, 1'b0, 8'h00, 1'b1);
    op8("tffff",   8'hFF, 8'hFF, 1'b1, 8'h00, 1'b1, 8'hFF, 1'b1);

    // Requests during RUN and DONE must be ignored.
    @(negedge clk);
    start8 = 1'b1; a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0;
    dones  = 0;
    busy_n = 0;
    s_got  = '0;
    c_got  = 1'b0;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      if (busy8) busy_n++;
      if (done8) begin
        dones++;
        s_got = sum8;
        c_got = cout8;
      end
      start8 = busy8;             // request on every RUN/DONE cycle only
      a8     = 8'hAA;
      b8     = 8'h55;
    end
    start8 = 1'b0;
    check("ign_dones",    32'(dones), 32'd1);
    check("ign_sum",      32'(s_got), 32'h30);
    check("ign_cout",     32'(c_got), 32'd0);
    check("ign_busy_len", 32'(busy_n), 32'd9);
    check("ign_sum_hold", 32'(sum8), 32'h30);

    // Reset during RUN discards the operation.
    @(negedge clk);
    start8 = 1'b1; a8 = 8'h77; b8 = 8'h11; cin8 = 1'b0;
    @(negedge clk);               // RUN cycle 1
    start8 = 1'b0;
    repeat (3) @(negedge clk);    // RUN cycle 4
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mrst_busy", 32'(busy8), 32'd0);
    check("mrst_done", 32'(done8), 32'd0);
    check("mrst_sum",  32'(sum8),  32'd0);
    check("mrst_cout", 32'(cout8), 32'd0);
    act = 0;
    repeat (12) begin
      @(negedge clk);
      if (done8 || busy8) act++;
    end
    check("mrst_quiet", 32'(act), 32'd0);
    op8("mrst_new", 8'h01, 8'h01, 1'b0, 8'h00, 1'b0, 8'h02, 1'b0);

    // WIDTH=1: full-adder truth table, one-cycle latency.
    for (int i = 0; i < 8; i++) begin
      v = 9'(i);
      @(negedge clk);
      start1 = 1'b1; a1 = v[2]; b1 = v[1]; cin1 = v[0];
      @(negedge clk);
      start1 = 1'b0;
      n = 0;
      while (!done1 && n < 10) begin
        @(negedge clk);
        n++;
      end
      check($sformatf("w1_lat_%0d", i), 32'(n), 32'd1);
      check($sformatf("w1_res_%0d", i), {30'd0, cout1, sum1}, 32'(fa_tbl[i]));
      @(negedge clk);
    end

    // WIDTH=4: exhaustive sweep with start held high.
    idx = 0;
    @(negedge clk);
    v = 9'(idx);
    start4 = 1'b1; a4 = v[8:5]; b4 = v[4:1]; cin4 = v[0];
    exp_q.push_back({5'd0, v[8:5]} + {5'd0, v[4:1]} + {8'd0, v[0]});
    idx  = 1;
    gap  = 0;
    seen = 0;
    for (int cyc = 0; cyc < 4000 && seen < 512; cyc++) begin
      @(negedge clk);
      gap++;
      if (done4) begin
        if (exp_q.size() == 0) begin
          check("w4_q_underflow", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("w4_res_%0d", seen), {23'd0, cout4, sum4}, 32'(e));
        end
        if (seen > 0) check($sformatf("w4_gap_%0d", seen), 32'(gap), 32'd6);
        gap = 0;
        seen++;
        if (idx < 512) begin
          v = 9'(idx);
          a4 = v[8:5]; b4 = v[4:1]; cin4 = v[0];
          exp_q.push_back({5'd0, v[8:5]} + {5'd0, v[4:1]} + {8'd0, v[0]});
          idx++;
        end else begin
          start4 = 1'b0;
        end
      end
    end
    start4 = 1'b0;
    check("w4_count",   32'(seen), 32'd512);
    check("w4_q_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/serial_add_ctrl.md
# serial_add_ctrl

Bit-serial addition controller that time-shares a single gate-level `FullAdder` cell across a WIDTH-bit operand pair. It latches two operands and a carry-in on a start request, then feeds the cell one bit per clock, LSB first, recirculating the carry through a flop. It returns the registered WIDTH-bit sum and carry-out with a one-cycle done pulse. It sits between a requesting unit and the shared adder cell and trades latency for area versus a WIDTH-cell ripple adder.

## Interface
- `WIDTH`, default 8: operand/sum width in bits; legal range ≥ 1.
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  request; sampled only in IDLE.
- `a`  in  WIDTH  operand A; captured on the accepting edge.
- `b`  in  WIDTH  operand B; captured on the accepting edge.
- `cin`  in  1  carry-in; captured on the accepting edge.
- `busy`  out  1  high in RUN and DONE.
- `done`  out  1  one-cycle pulse; result valid.
- `sum`  out  WIDTH  registered result; holds until the next completion.
- `cout`  out  1  registered carry-out; holds until the next completion.

## Operation
- Exactly one `FullAdder` instance, with ports (A, B, Cin, Sum, Cout). No other adder logic in the datapath.
- Internal state:
  - shift registers `sa` and `sb`, WIDTH bits each;
  - result shift register `sr`, WIDTH bits;
  - carry flop `c`;
  - bit counter, $clog2(WIDTH+1) bits;
  - 2-bit state: IDLE, RUN, DONE.
- IDLE:
  - `busy`=0 and `done`=0.
  - If `start`=1: load `sa`←`a`, `sb`←`b`, `c`←`cin`, counter←0, and go to RUN.
  - Otherwise stay in IDLE.
- RUN, once per cycle:
  - The cell inputs are `sa[0]`, `sb[0]`, `c`.
  - `c`←cell Cout.
  - `sr`←{cell Sum, `sr[WIDTH-1:1]`}.
  - `sa` and `sb` shift right by one.
  - Counter increments.
  - On the edge that processes bit WIDTH-1 (counter==WIDTH-1): load `sum`←{cell Sum, `sr[WIDTH-1:1]`} and `cout`←cell Cout, then go to DONE.
- DONE: `done`=1 for this cycle only, then go to IDLE unconditionally.
- `start` in RUN or DONE is ignored: not queued and not latched. Requesters must wait for `busy`=0.
- `sum` and `cout` change only on the RUN→DONE edge. They are stable while the next operation runs.
- Arithmetic: {`cout`,`sum`} = `a` + `b` + `cin`, as an unsigned (WIDTH+1)-bit result. No overflow flag.
- WIDTH=1: RUN lasts exactly one cycle. Behaviour is otherwise identical.
- Reset (`rst`=1 at an edge, dominates `start`):
  - state←IDLE;
  - `sum`, `cout`, `done`, `sr`, `sa`, `sb`, `c`, counter all ← 0.
  - An in-flight operation is discarded with no done pulse.
  - `start` held high through reset is accepted on the first edge after `rst` falls.

## Timing
- Reset values: `busy`=0, `done`=0, `sum`=0, `cout`=0.
- Let edge E0 be the edge where `start` is accepted.
  - `busy` rises after E0.
  - Bits 0..WIDTH-1 are processed on edges E1..EWIDTH.
  - `done`=1 and the new `sum`/`cout` are visible in the cycle after EWIDTH.
  - `busy` and `done` fall after EWIDTH+1.
- Latency from the accepting edge to `done`: WIDTH cycles. `busy` is high for WIDTH+1 cycles.
- Throughput with `start` held high: one operation per WIDTH+2 cycles. The IDLE cycle between operations is mandatory.
- The cell path is combinational within one cycle: register → cell → register. There is no multicycle path.

## Test plan
- WIDTH=8, `a`=0x5A, `b`=0x3C, `cin`=0 → `sum`=0x96, `cout`=0; `done` high exactly 8 cycles after the accepting edge; `busy` high for exactly 9 cycles.
- WIDTH=8, `a`=0xFF, `b`=0x00, `cin`=1 (full carry ripple) → `sum`=0x00, `cout`=1. Then `a`=0xFF, `b`=0xFF, `cin`=1 → `sum`=0xFF, `cout`=1; the previous result must hold until that `done`.
- WIDTH=8: start 0x10+0x20; pulse `start` with `a`=0xAA, `b`=0x55 on each RUN cycle and on the DONE cycle → exactly one `done`, with `sum`=0x30, `cout`=0. The ignored requests produce no further activity.
- WIDTH=8: start 0x77+0x11; assert `rst` for one cycle at the 4th RUN cycle → `busy`=0, `sum`=0x00, `cout`=0, no `done`. A new request of 0x01+0x01 then yields `sum`=0x02.
- WIDTH=1: all 8 combinations of `a`/`b`/`cin` → {`cout`,`sum`} matches the full-adder truth table; `done` arrives 1 cycle after acceptance.
- WIDTH=4: exhaustive sweep of 512 operand/carry combinations with `start` held high → every result equals `a`+`b`+`cin`, and `done` pulses are spaced exactly 6 cycles apart.
